// File: rtl/tx_pkg.sv
// Shared constants for the TX buffer read-commit scheduler: address width,
// publish-FSM encodings and requester IDs.
package tx_pkg;

    localparam int TX_ADDR_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b01,
        ST_HOLD = 2'b10
    } pub_state_e;

    localparam logic REQ_FD   = 1'b0;
    localparam logic REQ_DROP = 1'b1;

endpackage

// File: rtl/tx_rd_commit_sched_if.sv
// Release-request handshakes, write pointer and published read pointer
// between the TX buffer clients and the commit scheduler.
interface tx_rd_commit_sched_if
    import tx_pkg::*;
#(
    parameter int ADDR_W = TX_ADDR_W
);

    logic              fd_req;
    logic [ADDR_W-1:0] fd_qw;
    logic              fd_ack;
    logic              drop_req;
    logic [ADDR_W-1:0] drop_qw;
    logic              drop_ack;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] commited_rd_addr;
    logic              commit_pending;
    logic              overrun_err;

    modport master (
        output fd_req, fd_qw, drop_req, drop_qw, wr_addr,
        input  fd_ack, drop_ack, commited_rd_addr, commit_pending, overrun_err
    );

    modport slave (
        input  fd_req, fd_qw, drop_req, drop_qw, wr_addr,
        output fd_ack, drop_ack, commited_rd_addr, commit_pending, overrun_err
    );

endinterface

// File: rtl/tx_rd_commit_sched_rr_arb2.sv
// Two-way round-robin arbiter; a requester whose ack is currently high is
// masked so a request still held during its ack cycle is not granted twice.
module tx_rr_arb2
    import tx_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic [1:0] ack_mask,
    output logic [1:0] grant,
    output logic       grant_id
);

    logic [1:0] elig;
    logic       last_grant;

    assign elig = req & ~ack_mask;

    always_comb begin
        grant_id = REQ_FD;
        grant    = 2'b00;
        case (elig)
            2'b01:   grant_id = REQ_FD;
            2'b10:   grant_id = REQ_DROP;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = REQ_FD;
        endcase
        if (elig != 2'b00) begin
            grant = (grant_id == REQ_DROP) ? 2'b10 : 2'b01;
        end
    end

    // Reset to DROP so the frame-done path wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= REQ_DROP;
        end else if (elig != 2'b00) begin
            last_grant <= grant_id;
        end
    end

endmodule

// File: rtl/tx_rd_commit_sched.sv
// Owns the TX buffer committed read pointer: accepts round-robin releases,
// accumulates them into rd_ptr and republishes it at a rate-limited pace.
module tx_rd_commit_sched
    import tx_pkg::*;
#(
    parameter int ADDR_W      = TX_ADDR_W,
    parameter int HOLD_CYCLES = 8
) (
    input  logic clk,
    input  logic reset_n,
    tx_rd_commit_sched_if.slave bus
);

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    logic [1:0]        grant_p0;
    logic              grant_id_p0;
    logic [ADDR_W-1:0] sel_qw_p0;
    logic [ADDR_W-1:0] occ_p0;

    logic [ADDR_W-1:0] rd_ptr_p1;
    logic [ADDR_W-1:0] rd_ptr_nxt;
    logic              overrun_p1;
    logic              overrun_nxt;
    logic              fd_ack_p1;
    logic              drop_ack_p1;

    pub_state_e        state_q;
    pub_state_e        state_nxt;
    logic [7:0]        hold_cnt_q;
    logic [7:0]        hold_cnt_nxt;
    logic [ADDR_W-1:0] pub_addr_p2;
    logic [ADDR_W-1:0] pub_addr_nxt;

    tx_rr_arb2 u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      ({bus.drop_req, bus.fd_req}),
        .ack_mask ({drop_ack_p1, fd_ack_p1}),
        .grant    (grant_p0),
        .grant_id (grant_id_p0)
    );

    // Stage p0 -> p1: apply the granted release to rd_ptr, clamping at wr_addr.
    always_comb begin
        sel_qw_p0   = (grant_id_p0 == REQ_DROP) ? bus.drop_qw : bus.fd_qw;
        occ_p0      = bus.wr_addr - rd_ptr_p1;
        rd_ptr_nxt  = rd_ptr_p1;
        overrun_nxt = overrun_p1;
        if (grant_p0 != 2'b00) begin
            if (sel_qw_p0 <= occ_p0) begin
                rd_ptr_nxt = rd_ptr_p1 + sel_qw_p0;
            end else begin
                rd_ptr_nxt  = bus.wr_addr;
                overrun_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_p1   <= '0;
            overrun_p1  <= 1'b0;
            fd_ack_p1   <= 1'b0;
            drop_ack_p1 <= 1'b0;
        end else begin
            rd_ptr_p1   <= rd_ptr_nxt;
            overrun_p1  <= overrun_nxt;
            fd_ack_p1   <= grant_p0[0];
            drop_ack_p1 <= grant_p0[1];
        end
    end

    // Stage p1 -> p2: publish rd_ptr, then hold off further changes so the
    // clock-crossing stage sees each value long enough; releases coalesce meanwhile.
    always_comb begin
        state_nxt    = state_q;
        hold_cnt_nxt = hold_cnt_q;
        pub_addr_nxt = pub_addr_p2;
        case (state_q)
            ST_IDLE: begin
                if (rd_ptr_p1 != pub_addr_p2) begin
                    pub_addr_nxt = rd_ptr_p1;
                    hold_cnt_nxt = HOLD_LOAD;
                    state_nxt    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                hold_cnt_nxt = hold_cnt_q - 8'd1;
                if (hold_cnt_q <= 8'd1) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt    = ST_IDLE;
                hold_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            hold_cnt_q  <= '0;
            pub_addr_p2 <= '0;
        end else begin
            state_q     <= state_nxt;
            hold_cnt_q  <= hold_cnt_nxt;
            pub_addr_p2 <= pub_addr_nxt;
        end
    end

    assign bus.fd_ack           = fd_ack_p1;
    assign bus.drop_ack         = drop_ack_p1;
    assign bus.commited_rd_addr = pub_addr_p2;
    assign bus.commit_pending   = (rd_ptr_p1 != pub_addr_p2);
    assign bus.overrun_err      = overrun_p1;

endmodule

// File: tb/tb_tx_rd_commit_sched.sv
// Bench for tx_rd_commit_sched: directed scenarios plus randomized release
// batches checked against a pointer/occupancy model.
module tb_tx_rd_commit_sched;
    import tx_pkg::*;

    localparam int AW   = 10;
    localparam int HOLD = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    tx_rd_commit_sched_if #(.ADDR_W(AW)) bus ();

    tx_rd_commit_sched #(.ADDR_W(AW), .HOLD_CYCLES(HOLD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    int          cyc = 0;
    int          chg_q[$];
    int          both_ack = 0;
    logic [AW-1:0] prev_c = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (reset_n) begin
            if (bus.commited_rd_addr !== prev_c) chg_q.push_back(cyc);
            if (bus.fd_ack === 1'b1 && bus.drop_ack === 1'b1) both_ack <= both_ack + 1;
        end
        prev_c <= bus.commited_rd_addr;
    end

    logic [AW-1:0] m_ptr;
    logic          m_err;

    function automatic void model_rel(input logic [AW-1:0] qw, input logic [AW-1:0] wr);
        logic [AW-1:0] occ;
        occ = wr - m_ptr;
        if (qw <= occ) m_ptr = m_ptr + qw;
        else begin
            m_ptr = wr;
            m_err = 1'b1;
        end
    endfunction

    task automatic do_reset();
        reset_n      = 1'b0;
        bus.fd_req   = 1'b0;
        bus.drop_req = 1'b0;
        bus.fd_qw    = '0;
        bus.drop_qw  = '0;
        bus.wr_addr  = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chg_q.delete();
        both_ack = 0;
    endtask

    task automatic fd_release(input logic [AW-1:0] qw, output bit ok);
        bus.fd_qw  = qw;
        bus.fd_req = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.fd_ack === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        bus.fd_req = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        checks++; if (bus.commited_rd_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d want 0", bus.commited_rd_addr); end
        checks++; if (bus.fd_ack !== 1'b0 || bus.drop_ack !== 1'b0) begin errors++; $display("FAIL reset_acks: got %b%b want 00", bus.fd_ack, bus.drop_ack); end
        checks++; if (bus.commit_pending !== 1'b0 || bus.overrun_err !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b want 00", bus.commit_pending, bus.overrun_err); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        bus.wr_addr = 10'd100;
        bus.fd_qw   = 10'd10;
        bus.fd_req  = 1'b1;
        @(negedge clk);
        checks++; if (bus.fd_ack !== 1'b1 || bus.drop_ack !== 1'b0) begin errors++; $display("FAIL t1_ack: got fd=%b drop=%b want 1 0", bus.fd_ack, bus.drop_ack); end
        checks++; if (bus.commit_pending !== 1'b1) begin errors++; $display("FAIL t1_pend_hi: got %b want 1", bus.commit_pending); end
        checks++; if (bus.commited_rd_addr !== 10'd0) begin errors++; $display("FAIL t1_addr_early: got %0d want 0", bus.commited_rd_addr); end
        bus.fd_req = 1'b0;
        @(negedge clk);
        checks++; if (bus.fd_ack !== 1'b0) begin errors++; $display("FAIL t1_ack_pulse: got %b want 0", bus.fd_ack); end
        checks++; if (bus.commited_rd_addr !== 10'd10) begin errors++; $display("FAIL t1_addr: got %0d want 10", bus.commited_rd_addr); end
        checks++; if (bus.commit_pending !== 1'b0) begin errors++; $display("FAIL t1_pend_lo: got %b want 0", bus.commit_pending); end
    endtask

    task automatic test_arb();
        int order[$];
        do_reset();
        bus.wr_addr  = 10'd200;
        bus.fd_qw    = 10'd5;
        bus.drop_qw  = 10'd5;
        bus.fd_req   = 1'b1;
        bus.drop_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.fd_ack === 1'b1) begin order.push_back(0); bus.fd_req = 1'b0; end
            if (bus.drop_ack === 1'b1) begin order.push_back(1); bus.drop_req = 1'b0; end
        end
        checks++; if (order.size() != 2) begin errors++; $display("FAIL t2_ack_count: got %0d want 2", order.size()); end
        else begin
            checks++; if (order[0] != 0 || order[1] != 1) begin errors++; $display("FAIL t2_order: got %0d,%0d want 0,1", order[0], order[1]); end
        end
        repeat (12) @(negedge clk);
        checks++; if (bus.commited_rd_addr !== 10'd10) begin errors++; $display("FAIL t2_addr: got %0d want 10", bus.commited_rd_addr); end
        checks++; if (both_ack != 0) begin errors++; $display("FAIL t2_dual_ack: got %0d cycles want 0", both_ack); end
    endtask

    task automatic test_back_to_back();
        int nok = 0;
        bit ok;
        do_reset();
        bus.wr_addr = 10'd100;
        for (int k = 0; k < 20; k++) begin
            fd_release(10'd1, ok);
            if (ok) nok++;
        end
        repeat (12) @(negedge clk);
        checks++; if (nok != 20) begin errors++; $display("FAIL t3_acks: got %0d want 20", nok); end
        checks++; if (bus.commited_rd_addr !== 10'd20) begin errors++; $display("FAIL t3_addr: got %0d want 20", bus.commited_rd_addr); end
        checks++; if (chg_q.size() < 3) begin errors++; $display("FAIL t3_changes: got %0d want >=3", chg_q.size()); end
        for (int i = 1; i < chg_q.size(); i++) begin
            checks++; if (chg_q[i] - chg_q[i-1] != HOLD) begin errors++; $display("FAIL t3_spacing: got %0d want %0d", chg_q[i] - chg_q[i-1], HOLD); end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        bus.wr_addr = 10'd1020;
        fd_release(10'd1020, ok);
        repeat (12) @(negedge clk);
        checks++; if (bus.commited_rd_addr !== 10'd1020) begin errors++; $display("FAIL t4_pre: got %0d want 1020", bus.commited_rd_addr); end
        bus.wr_addr = 10'd4;
        fd_release(10'd8, ok);
        repeat (12) @(negedge clk);
        checks++; if (bus.commited_rd_addr !== 10'd4 || bus.overrun_err !== 1'b0) begin errors++; $display("FAIL t4_wrap: got addr=%0d err=%b want 4 0", bus.commited_rd_addr, bus.overrun_err); end
        fd_release(10'd1, ok);
        repeat (12) @(negedge clk);
        checks++; if (bus.commited_rd_addr !== 10'd4 || bus.overrun_err !== 1'b1) begin errors++; $display("FAIL t4_overrun: got addr=%0d err=%b want 4 1", bus.commited_rd_addr, bus.overrun_err); end
        bus.wr_addr = 10'd10;
        fd_release(10'd2, ok);
        repeat (12) @(negedge clk);
        checks++; if (bus.commited_rd_addr !== 10'd6 || bus.overrun_err !== 1'b1) begin errors++; $display("FAIL t4_sticky: got addr=%0d err=%b want 6 1", bus.commited_rd_addr, bus.overrun_err); end
    endtask

    task automatic test_zero();
        bit ok;
        bit seen = 1'b0;
        do_reset();
        bus.wr_addr = 10'd50;
        fd_release(10'd0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL t5_ack: got none want ack"); end
        for (int i = 0; i < 10; i++) begin
            if (bus.commit_pending !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen) begin errors++; $display("FAIL t5_pending: got 1 want 0"); end
        checks++; if (bus.commited_rd_addr !== 10'd0) begin errors++; $display("FAIL t5_addr: got %0d want 0", bus.commited_rd_addr); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        bus.wr_addr = 10'd100;
        fd_release(10'd10, ok);
        @(negedge clk);
        fd_release(10'd5, ok);
        checks++; if (bus.commit_pending !== 1'b1 || bus.commited_rd_addr !== 10'd10) begin errors++; $display("FAIL t6_hold: got pend=%b addr=%0d want 1 10", bus.commit_pending, bus.commited_rd_addr); end
        bus.fd_qw  = 10'd7;
        bus.fd_req = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (bus.commited_rd_addr !== '0 || bus.commit_pending !== 1'b0 || bus.fd_ack !== 1'b0 || bus.drop_ack !== 1'b0 || bus.overrun_err !== 1'b0) begin
            errors++; $display("FAIL t6_async: got addr=%0d pend=%b acks=%b%b err=%b want all 0", bus.commited_rd_addr, bus.commit_pending, bus.fd_ack, bus.drop_ack, bus.overrun_err);
        end
        @(negedge clk);
        reset_n = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.fd_ack === 1'b1) begin ok = 1'b1; break; end
        end
        bus.fd_req = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL t6_reack: got none want ack"); end
        @(negedge clk);
        checks++; if (bus.commited_rd_addr !== 10'd7) begin errors++; $display("FAIL t6_publish: got %0d want 7", bus.commited_rd_addr); end
    endtask

    task automatic test_random();
        logic [AW-1:0] wr, fqw, dqw;
        bit fd_pend, dr_pend;
        do_reset();
        m_ptr = '0;
        m_err = 1'b0;
        wr    = '0;
        for (int b = 0; b < 30; b++) begin
            wr = wr + AW'($urandom_range(0, 60));
            bus.wr_addr = wr;
            fqw = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 1023)) : AW'($urandom_range(0, 20));
            dqw = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 1023)) : AW'($urandom_range(0, 20));
            fd_pend = ($urandom_range(0, 3) != 0);
            dr_pend = ($urandom_range(0, 2) != 0);
            bus.fd_qw    = fqw;
            bus.drop_qw  = dqw;
            bus.fd_req   = fd_pend;
            bus.drop_req = dr_pend;
            for (int i = 0; i < 20 && (fd_pend || dr_pend); i++) begin
                @(negedge clk);
                if (bus.fd_ack === 1'b1) begin
                    checks++; if (!fd_pend) begin errors++; $display("FAIL rnd_fd_spurious: got ack want none"); end
                    model_rel(fqw, wr);
                    fd_pend = 1'b0;
                    bus.fd_req = 1'b0;
                end
                if (bus.drop_ack === 1'b1) begin
                    checks++; if (!dr_pend) begin errors++; $display("FAIL rnd_drop_spurious: got ack want none"); end
                    model_rel(dqw, wr);
                    dr_pend = 1'b0;
                    bus.drop_req = 1'b0;
                end
            end
            checks++; if (fd_pend || dr_pend) begin errors++; $display("FAIL rnd_timeout: got pending fd=%b drop=%b want served", fd_pend, dr_pend); end
            bus.fd_req   = 1'b0;
            bus.drop_req = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (b % 5 == 4) begin
                repeat (12) @(negedge clk);
                checks++; if (bus.commited_rd_addr !== m_ptr || bus.overrun_err !== m_err) begin
                    errors++; $display("FAIL rnd_state: got addr=%0d err=%b want %0d %b", bus.commited_rd_addr, bus.overrun_err, m_ptr, m_err);
                end
                checks++; if (bus.commit_pending !== 1'b0) begin errors++; $display("FAIL rnd_pending: got 1 want 0"); end
            end
        end
        for (int i = 1; i < chg_q.size(); i++) begin
            checks++; if (chg_q[i] - chg_q[i-1] < HOLD) begin errors++; $display("FAIL rnd_spacing: got %0d want >=%0d", chg_q[i] - chg_q[i-1], HOLD); end
        end
        checks++; if (both_ack != 0) begin errors++; $display("FAIL rnd_dual_ack: got %0d cycles want 0", both_ack); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.fd_req   = 1'b0;
        bus.drop_req = 1'b0;
        bus.fd_qw    = '0;
        bus.drop_qw  = '0;
        bus.wr_addr  = '0;
        test_reset();
        test_single();
        test_arb();
        test_back_to_back();
        test_wrap();
        test_zero();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
